// File: rtl/indptr_row_reader.sv
// indptr_row_reader
// Read-side engine for the double-buffered CSR row-pointer (indptr) memory.
// On a start command it walks the selected bank. Each cycle it reads
// indptr[i] on port 1 and indptr[i+1] on port 2 of that bank, and emits one
// descriptor per row (index, first nonzero offset, nonzero count) on a
// valid/ready stream. A one-cycle done pulse hands the bank back to the loader.
//
// Optional feature: define INDPTR_EMPTY_ROW_SKIP_EN to drop zero-length rows
// from the stream. Their credit is released on the cycle the data returns.
module indptr_row_reader #(
    parameter int k             = 1024,
    parameter int addressWidth  = $clog2(k + 1),
    parameter int dataportWidth = $clog2(k * k / 32),
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     bankSel,
    input  logic [addressWidth-1:0]  numRows,
    output logic                     busy,
    output logic                     done,
    output logic                     enableA,
    output logic                     enableB,
    output logic [addressWidth-1:0]  addressportA1,
    output logic [addressWidth-1:0]  addressportA2,
    output logic [addressWidth-1:0]  addressportB1,
    output logic [addressWidth-1:0]  addressportB2,
    input  logic [dataportWidth-1:0] readportA1,
    input  logic [dataportWidth-1:0] readportA2,
    input  logic [dataportWidth-1:0] readportB1,
    input  logic [dataportWidth-1:0] readportB2,
    output logic                     rowValid,
    input  logic                     rowReady,
    output logic [addressWidth-1:0]  rowIndex,
    output logic [dataportWidth-1:0] rowStart,
    output logic [dataportWidth-1:0] rowLength
);

    // Memory read latency in cycles. vld_pipe[0] marks the cycle the enable
    // is on the memory pins, and vld_pipe[STAGES] marks the cycle the data is on
    // the read ports.
    localparam int STAGES = 2;
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [addressWidth-1:0]  idx;
        logic [dataportWidth-1:0] ofs;
        logic [dataportWidth-1:0] len;
    } desc_t;

    // FSM and registered memory-side outputs
    state_t                    state_q;
    logic                      bank_q;
    logic [addressWidth-1:0]   num_q;
    logic [addressWidth-1:0]   row_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      en_a_q;
    logic                      en_b_q;
    logic [addressWidth-1:0]   addr_a1_q;
    logic [addressWidth-1:0]   addr_a2_q;
    logic [addressWidth-1:0]   addr_b1_q;
    logic [addressWidth-1:0]   addr_b2_q;

    // Read pipeline tracking
    logic [STAGES:0]                    vld_pipe_q;
    logic [STAGES:0]                    vld_pipe_d;
    logic [STAGES:0][addressWidth-1:0]  idx_pipe_q;
    logic [STAGES:0][addressWidth-1:0]  idx_pipe_d;
    logic [1:0]                         in_flight_q;
    logic [1:0]                         in_flight_d;

    // Descriptor FIFO
    desc_t                     fifo_mem_q [FIFO_DEPTH];
    desc_t                     fifo_mem_d [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr_q;
    logic [PW-1:0]             wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q;
    logic [PW-1:0]             rd_ptr_d;
    logic [CW-1:0]             fifo_count_q;
    logic [CW-1:0]             fifo_count_d;

    // Combinational control
    logic                      issue_go;
    logic                      issue_bank;
    logic [addressWidth-1:0]   issue_row;
    logic [dataportWidth-1:0]  ret_p1;
    logic [dataportWidth-1:0]  ret_p2;
    desc_t                     ret_desc;
    desc_t                     head;
    logic                      push;
    logic                      pop;
    int                        occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Issue decision. A read may go out only if every outstanding row still
    // has a FIFO slot once it returns. Outstanding rows are the FIFO contents,
    // the two pipeline stages after the memory pins, and the read on the pins
    // this cycle. A pop this cycle frees one slot.
    always_comb begin
        issue_bank = (state_q == IDLE) ? bankSel : bank_q;
        issue_row  = (state_q == IDLE) ? '0 : row_q;
        pop        = (fifo_count_q != '0) && rowReady;
        occ        = int'(fifo_count_q) + int'(in_flight_q) + int'(vld_pipe_q[0]) - int'(pop);
        issue_go   = 1'b0;
        if (state_q == IDLE)
            issue_go = start && (numRows != '0);
        else if (state_q == ISSUE)
            issue_go = (occ < FIFO_DEPTH);
    end

    // Form the returning descriptor from the walked bank's read ports
    always_comb begin
        ret_p1       = bank_q ? readportB1 : readportA1;
        ret_p2       = bank_q ? readportB2 : readportA2;
        ret_desc.idx = idx_pipe_q[STAGES];
        ret_desc.ofs = ret_p1;
        ret_desc.len = ret_p2 - ret_p1;
`ifdef INDPTR_EMPTY_ROW_SKIP_EN
        push = vld_pipe_q[STAGES] && (ret_desc.len != '0);
`else
        push = vld_pipe_q[STAGES];
`endif
    end

    // Next-state for the pipeline trackers, the in-flight counter and the FIFO
    always_comb begin
        vld_pipe_d   = {vld_pipe_q[STAGES-1:0], issue_go};
        idx_pipe_d   = {idx_pipe_q[STAGES-1:0], issue_row};
        in_flight_d  = in_flight_q + {1'b0, vld_pipe_q[0]} - {1'b0, vld_pipe_q[STAGES]};
        fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
        wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_mem_d   = fifo_mem_q;
        if (push)
            fifo_mem_d[wr_ptr_q] = ret_desc;
    end

    // Stream outputs. The payload is forced to zero while no descriptor is valid.
    always_comb begin
        head      = fifo_mem_q[rd_ptr_q];
        rowValid  = (fifo_count_q != '0);
        rowIndex  = rowValid ? head.idx : '0;
        rowStart  = rowValid ? head.ofs : '0;
        rowLength = rowValid ? head.len : '0;
    end

    // Walk FSM. Enables and addresses are registered and cleared every cycle
    // unless a read is issued. Only the selected bank is ever driven.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bank_q    <= 1'b0;
            num_q     <= '0;
            row_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            en_a_q    <= 1'b0;
            en_b_q    <= 1'b0;
            addr_a1_q <= '0;
            addr_a2_q <= '0;
            addr_b1_q <= '0;
            addr_b2_q <= '0;
        end else begin
            done_q    <= 1'b0;
            en_a_q    <= issue_go && !issue_bank;
            en_b_q    <= issue_go && issue_bank;
            addr_a1_q <= (issue_go && !issue_bank) ? issue_row : '0;
            addr_a2_q <= (issue_go && !issue_bank) ? issue_row + 1'b1 : '0;
            addr_b1_q <= (issue_go && issue_bank) ? issue_row : '0;
            addr_b2_q <= (issue_go && issue_bank) ? issue_row + 1'b1 : '0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bank_q <= bankSel;
                        num_q  <= numRows;
                        busy_q <= 1'b1;
                        if (numRows == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            // Row 0 is issued from IDLE itself.
                            row_q   <= addressWidth'(1);
                            state_q <= (numRows == addressWidth'(1)) ? DRAIN : ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_go) begin
                        row_q <= row_q + 1'b1;
                        if (row_q == num_q - 1'b1)
                            state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Look at next-cycle occupancy so done lands in the cycle
                    // right after the last handshake.
                    if (in_flight_d == '0 && fifo_count_d == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pipeline, in-flight counter and FIFO pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q   <= '0;
            idx_pipe_q   <= '0;
            in_flight_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            vld_pipe_q   <= vld_pipe_d;
            idx_pipe_q   <= idx_pipe_d;
            in_flight_q  <= in_flight_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    // FIFO storage. No reset is needed because the outputs are gated by rowValid.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign enableA       = en_a_q;
    assign enableB       = en_b_q;
    assign addressportA1 = addr_a1_q;
    assign addressportA2 = addr_a2_q;
    assign addressportB1 = addr_b1_q;
    assign addressportB2 = addr_b2_q;

endmodule

// File: tb/tb_indptr_row_reader.sv
// Testbench for indptr_row_reader. A 2-cycle-latency dual-bank memory model
// feeds the design. A reference model computes the expected descriptors
// from the indptr arrays, and a monitor pops and compares them.
module tb_indptr_row_reader;
    localparam int K  = 1024;
    localparam int AW = 11;
    localparam int DW = 15;

    logic          clk = 1'b0;
    logic          rst, start, bankSel, rowReady;
    logic [AW-1:0] numRows;
    logic          busy, done, enableA, enableB, rowValid;
    logic [AW-1:0] addressportA1, addressportA2, addressportB1, addressportB2, rowIndex;
    logic [DW-1:0] readportA1 = '0, readportA2 = '0, readportB1 = '0, readportB2 = '0;
    logic [DW-1:0] rowStart, rowLength;

    indptr_row_reader dut (
        .clk(clk), .rst(rst), .start(start), .bankSel(bankSel), .numRows(numRows),
        .busy(busy), .done(done), .enableA(enableA), .enableB(enableB),
        .addressportA1(addressportA1), .addressportA2(addressportA2),
        .addressportB1(addressportB1), .addressportB2(addressportB2),
        .readportA1(readportA1), .readportA2(readportA2),
        .readportB1(readportB1), .readportB2(readportB2),
        .rowValid(rowValid), .rowReady(rowReady),
        .rowIndex(rowIndex), .rowStart(rowStart), .rowLength(rowLength)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: address sampled at the edge, data on the port two cycles later
    logic [DW-1:0] memA [0:K];
    logic [DW-1:0] memB [0:K];
    logic [DW-1:0] a1_s = '0, a2_s = '0, b1_s = '0, b2_s = '0;
    always @(posedge clk) begin
        a1_s <= enableA ? memA[addressportA1] : '0;
        a2_s <= enableA ? memA[addressportA2] : '0;
        b1_s <= enableB ? memB[addressportB1] : '0;
        b2_s <= enableB ? memB[addressportB2] : '0;
        readportA1 <= a1_s;
        readportA2 <= a2_s;
        readportB1 <= b1_s;
        readportB2 <= b2_s;
    end

    typedef struct {
        int idx;
        int ofs;
        int len;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: row i -> (i, p[i], (p[i+1]-p[i]) mod 2^DW)
    task automatic push_expected(input bit bank, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            int   s, nx;
            s     = bank ? int'(memB[i]) : int'(memA[i]);
            nx    = bank ? int'(memB[i+1]) : int'(memA[i+1]);
            e.idx = i;
            e.ofs = s;
            e.len = (nx - s) & ((1 << DW) - 1);
`ifdef INDPTR_EMPTY_ROW_SKIP_EN
            if (e.len == 0) continue;
`endif
            exp_q.push_back(e);
        end
    endtask

    // Ready pattern driver: 0 = always high, 1 = 1-0-0-1 repeating, 2 = random
    int ready_mode = 0;
    int rpat = 0;
    initial begin
        rowReady = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: rowReady = 1'b1;
                1: begin rowReady = (rpat == 0 || rpat == 3); rpat = (rpat + 1) % 4; end
                default: rowReady = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor state shared with the walk task
    bit            walk_bank = 1'b0;
    int            ena_cnt, enb_cnt, excl_err, issued, popped, max_out;
    int            first_valid = -1;
    bit            stall_prev = 1'b0;
    logic [AW+2*DW-1:0] prev_pl;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
                continue;
            end
            if (enableA) ena_cnt++;
            if (enableB) enb_cnt++;
            if (walk_bank == 1'b0 && (enableB || addressportB1 != '0 || addressportB2 != '0)) excl_err++;
            if (walk_bank == 1'b1 && (enableA || addressportA1 != '0 || addressportA2 != '0)) excl_err++;
            issued += int'(enableA) + int'(enableB);
            if (issued - popped > max_out) max_out = issued - popped;
            if (stall_prev)
                check("stall_stable", {rowValid, rowIndex, rowStart, rowLength}, {1'b1, prev_pl});
            if (rowValid && first_valid < 0) first_valid = cyc;
            if (rowValid && rowReady) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_desc: got idx %0d start %0d len %0d, expected none", rowIndex, rowStart, rowLength);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("desc", {rowIndex, rowStart, rowLength}, {AW'(e.idx), DW'(e.ofs), DW'(e.len)});
                end
                popped++;
            end
            stall_prev = rowValid && !rowReady;
            prev_pl    = {rowIndex, rowStart, rowLength};
        end
    end

    task automatic check_outputs_zero(input string name);
        check({name, "_ctrl"}, {busy, done, rowValid, enableA, enableB}, '0);
        check({name, "_data"}, {addressportA1, addressportA2, addressportB1, addressportB2,
                                rowIndex, rowStart, rowLength}, '0);
    endtask

    // One complete walk with scoreboard, timing and bank/credit checks
    task automatic run_walk(input bit bank, input int n, input int mode, input bit timing, input bit poke);
        int t0, done_cyc;
        bit got;
        ready_mode = mode;
        rpat = 0;
        push_expected(bank, n);
        @(posedge clk); #1;
        walk_bank = bank; ena_cnt = 0; enb_cnt = 0; excl_err = 0;
        issued = 0; popped = 0; max_out = 0; first_valid = -1;
        start = 1'b1; bankSel = bank; numRows = AW'(n); t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; bankSel = 1'($urandom); numRows = AW'($urandom);
        got = 1'b0; done_cyc = -1;
        for (int w = 0; w < n * 8 + 50 && !got; w++) begin
            if (poke && w == 3) begin start = 1'b1; bankSel = !bank; numRows = AW'(5); end
            if (poke && w == 4) start = 1'b0;
            @(negedge clk);
            if (done) begin got = 1'b1; done_cyc = cyc; end
        end
        start = 1'b0;
        check("done_seen", got, 1'b1);
        if (timing) begin
            check("done_cycle", done_cyc, (n == 0) ? t0 + 1 : t0 + n + 4);
            if (n > 0) check("first_valid_cycle", first_valid, t0 + 4);
        end
        if (n == 0) check("no_rowvalid", first_valid < 0, 1'b1);
        check("q_empty", exp_q.size(), 0);
        check("enable_count", ena_cnt + enb_cnt, n);
        check("bank_excl", excl_err, 0);
`ifndef INDPTR_EMPTY_ROW_SKIP_EN
        check("credit_le_4", max_out <= 4, 1'b1);
`endif
        @(negedge clk);
        check("busy_after_done", busy, 1'b0);
        exp_q.delete();
    endtask

    task automatic fill_random(input bit bank);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i <= K; i++) begin
            if ($urandom_range(0, 3) != 0) v = DW'($urandom);
            if (bank) memB[i] = v; else memA[i] = v;
        end
    endtask

    initial begin
        int t0;
        rst = 1'b1; start = 1'b0; bankSel = 1'b0; numRows = '0;
        for (int i = 0; i <= K; i++) begin memA[i] = '0; memB[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Directed example on bank A, then on bank B with stalls
        memA[0] = 0; memA[1] = 3; memA[2] = 3; memA[3] = 7; memA[4] = 10;
        memB[0] = 0; memB[1] = 3; memB[2] = 3; memB[3] = 7; memB[4] = 10;
        run_walk(1'b0, 4, 0, 1'b1, 1'b0);
        run_walk(1'b1, 4, 1, 1'b0, 1'b0);

        // Empty walk
        run_walk(1'b0, 0, 0, 1'b1, 1'b0);

        // Full bank, indptr[i] = i*32 (top entry wraps modulo 2^DW)
        for (int i = 0; i <= K; i++) memA[i] = DW'(i * 32);
        run_walk(1'b0, K, 0, 1'b1, 1'b0);

        // Reset in cycle t+5 of a 100-row walk, then replay
        fill_random(1'b0);
        ready_mode = 0;
        push_expected(1'b0, 100);
        @(posedge clk); #1;
        walk_bank = 1'b0; start = 1'b1; bankSel = 1'b0; numRows = AW'(100); t0 = cyc;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 exp_q.delete();
        @(negedge clk);
        check_outputs_zero("mid_reset");
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        run_walk(1'b0, 100, 2, 1'b0, 1'b0);

        // Start pulsed while busy must be ignored
        fill_random(1'b1);
        run_walk(1'b1, 30, 0, 1'b0, 1'b1);

        // Randomized walks with random backpressure
        for (int r = 0; r < 6; r++) begin
            bit b;
            b = 1'($urandom);
            fill_random(b);
            run_walk(b, int'($urandom_range(1, 40)), 2, 1'b0, 1'b0);
        end

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
